word_byte_serializer: RTL and testbench

WORD_BYTE_SERIALIZER -- requirements
Module: word_byte_serializer

---
 rtl/word_byte_serializer.sv | 144 ++++++++++++++
 tb/tb_word_byte_serializer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/word_byte_serializer.sv
// ---------------------------------------------------------------------------
// word_byte_serializer
//
// Purpose:
//   Splits a TAM_DATA-bit word into bytes and writes them one per cycle into
//   a downstream TX FIFO.
//   - The byte order is selectable: MSB first or LSB first.
//   - The number of bytes sent from each word is selectable.
//   - Writing pauses for as long as the FIFO reports almost-full.
//
// Ports:
//   i_clk               single clock, rising edge
//   i_reset             synchronous, active-high reset
//   i_palabra           word to serialize
//   i_valid             word request; accepted when i_valid && o_ready
//   i_num_bytes         bytes to send from the word (0 or > N_BYTES = all)
//   i_fifo_full         downstream FIFO almost-full (one slot still free)
//   o_ready             block can accept a word this cycle
//   o_byte              byte written into the FIFO (registered)
//   o_write_fifo_enable one-cycle write strobe per byte (registered)
//   o_done              one-cycle pulse alongside the last byte's strobe
//   o_busy              high while a word is being sent
//
// FSM states:
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for a word; o_ready = 1
//   ST_SEND | one byte scheduled per cycle in which the FIFO is not full
// ---------------------------------------------------------------------------
module word_byte_serializer #(
    parameter  int TAM_DATA  = 32,
    parameter  int MSB_FIRST = 1,
    localparam int N_BYTES   = TAM_DATA / 8,
    localparam int CW        = $clog2(N_BYTES + 1)
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [TAM_DATA-1:0] i_palabra,
    input  logic                i_valid,
    input  logic [CW-1:0]       i_num_bytes,
    input  logic                i_fifo_full,
    output logic                o_ready,
    output logic [7:0]          o_byte,
    output logic                o_write_fifo_enable,
    output logic                o_done,
    output logic                o_busy
);

    localparam logic [CW-1:0] N_BYTES_CW = CW'(N_BYTES);
    localparam logic [CW-1:0] ONE_CW     = CW'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t               r_state;
    logic [TAM_DATA-1:0]  r_word;
    logic [CW-1:0]        r_count;
    logic [CW-1:0]        r_idx;
    logic [7:0]           r_byte;
    logic                 r_wr;
    logic                 r_done;

    logic [CW-1:0]        w_eff_count;
    logic [7:0]           w_sel_byte;
    logic                 w_last;

    // A count of zero, or any count beyond the word size, means "whole word".
    always_comb begin
        w_eff_count = i_num_bytes;
        if ((i_num_bytes == '0) || (i_num_bytes > N_BYTES_CW)) begin
            w_eff_count = N_BYTES_CW;
        end
    end

    // The byte mux is built as a decode of the index. This keeps every part
    // select constant, whatever value the index register holds.
    always_comb begin
        w_sel_byte = 8'h00;
        for (int k = 0; k < N_BYTES; k++) begin
            if (r_idx == CW'(k)) begin
                if (MSB_FIRST != 0) begin
                    w_sel_byte = r_word[TAM_DATA-1-8*k -: 8];
                end else begin
                    w_sel_byte = r_word[8*k +: 8];
                end
            end
        end
    end

    assign w_last = (r_idx == (r_count - ONE_CW));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_word  <= '0;
            r_count <= '0;
            r_idx   <= '0;
            r_byte  <= 8'h00;
            r_wr    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_wr   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_valid) begin
                        r_word  <= i_palabra;
                        r_count <= w_eff_count;
                        r_idx   <= '0;
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // While the FIFO is full, the index and o_byte are held.
                    if (!i_fifo_full) begin
                        r_byte <= w_sel_byte;
                        r_wr   <= 1'b1;
                        if (w_last) begin
                            // The index is cleared here rather than advanced,
                            // so it never goes past count-1.
                            r_done  <= 1'b1;
                            r_idx   <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_idx <= r_idx + ONE_CW;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_ready             = (r_state == ST_IDLE);
    assign o_busy              = (r_state == ST_SEND);
    assign o_byte              = r_byte;
    assign o_write_fifo_enable = r_wr;
    assign o_done              = r_done;

endmodule

// File: tb/tb_word_byte_serializer.sv
// ---------------------------------------------------------------------------
// tb_word_byte_serializer
//
// Purpose:
//   Directed bench for word_byte_serializer.
//
// Instances:
//   dut_a   32-bit, MSB first
//   dut_b   32-bit, LSB first
//   dut_c   64-bit, MSB first
//
// Timing:
//   Inputs are changed and outputs are sampled on the falling edge. Every
//   cycle is checked against hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_word_byte_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // dut_a: 32-bit MSB first
    logic        a_rst, a_valid, a_full;
    logic [31:0] a_pal;
    logic [2:0]  a_nb;
    logic        a_ready, a_wr, a_done, a_busy;
    logic [7:0]  a_byte;

    // dut_b: 32-bit LSB first
    logic        b_rst, b_valid, b_full;
    logic [31:0] b_pal;
    logic [2:0]  b_nb;
    logic        b_ready, b_wr, b_done, b_busy;
    logic [7:0]  b_byte;

    // dut_c: 64-bit MSB first
    logic        c_rst, c_valid, c_full;
    logic [63:0] c_pal;
    logic [3:0]  c_nb;
    logic        c_ready, c_wr, c_done, c_busy;
    logic [7:0]  c_byte;

    word_byte_serializer #(.TAM_DATA(32), .MSB_FIRST(1)) dut_a (
        .i_clk               (clk),
        .i_reset             (a_rst),
        .i_palabra           (a_pal),
        .i_valid             (a_valid),
        .i_num_bytes         (a_nb),
        .i_fifo_full         (a_full),
        .o_ready             (a_ready),
        .o_byte              (a_byte),
        .o_write_fifo_enable (a_wr),
        .o_done              (a_done),
        .o_busy              (a_busy)
    );

    word_byte_serializer #(.TAM_DATA(32), .MSB_FIRST(0)) dut_b (
        .i_clk               (clk),
        .i_reset             (b_rst),
        .i_palabra           (b_pal),
        .i_valid             (b_valid),
        .i_num_bytes         (b_nb),
        .i_fifo_full         (b_full),
        .o_ready             (b_ready),
        .o_byte              (b_byte),
        .o_write_fifo_enable (b_wr),
        .o_done              (b_done),
        .o_busy              (b_busy)
    );

    word_byte_serializer #(.TAM_DATA(64), .MSB_FIRST(1)) dut_c (
        .i_clk               (clk),
        .i_reset             (c_rst),
        .i_palabra           (c_pal),
        .i_valid             (c_valid),
        .i_num_bytes         (c_nb),
        .i_fifo_full         (c_full),
        .o_ready             (c_ready),
        .o_byte              (c_byte),
        .o_write_fifo_enable (c_wr),
        .o_done              (c_done),
        .o_busy              (c_busy)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, then check one DUT's outputs.
    // The byte is only checked when a strobe is expected.
    task automatic step(input int d, input logic ew, input logic [7:0] eb,
                        input logic ed, input logic er, input string tag);
        logic       o_wr, o_done, o_ready, o_busy;
        logic [7:0] o_byte;
        @(negedge clk);
        case (d)
            0:       begin o_wr = a_wr; o_byte = a_byte; o_done = a_done; o_ready = a_ready; o_busy = a_busy; end
            1:       begin o_wr = b_wr; o_byte = b_byte; o_done = b_done; o_ready = b_ready; o_busy = b_busy; end
            default: begin o_wr = c_wr; o_byte = c_byte; o_done = c_done; o_ready = c_ready; o_busy = c_busy; end
        endcase
        check_val({tag, "_wr"}, 64'(o_wr), 64'(ew));
        if (ew) check_val({tag, "_byte"}, 64'(o_byte), 64'(eb));
        check_val({tag, "_done"}, 64'(o_done), 64'(ed));
        check_val({tag, "_ready"}, 64'(o_ready), 64'(er));
        check_val({tag, "_busy"}, 64'(o_busy), 64'(!er));
    endtask

    initial begin
        a_rst = 1'b1; a_valid = 1'b0; a_full = 1'b0; a_pal = '0; a_nb = '0;
        b_rst = 1'b1; b_valid = 1'b0; b_full = 1'b0; b_pal = '0; b_nb = '0;
        c_rst = 1'b1; c_valid = 1'b0; c_full = 1'b0; c_pal = '0; c_nb = '0;
        repeat (2) @(posedge clk);

        // Reset values on all three instances
        step(0, 1'b0, 8'h00, 1'b0, 1'b1, "rst_a");
        check_val("rst_a_byte", 64'(a_byte), 64'h00);
        check_val("rst_b_byte", 64'(b_byte), 64'h00);
        check_val("rst_b_ready", 64'(b_ready), 64'h1);
        check_val("rst_c_byte", 64'(c_byte), 64'h00);
        check_val("rst_c_ready", 64'(c_ready), 64'h1);
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
        step(0, 1'b0, 8'h00, 1'b0, 1'b1, "idle_a");

        // Full word, MSB first
        a_valid = 1'b1; a_pal = 32'hA1B2C3D4; a_nb = 3'd0;
        step(0, 1'b0, 8'h00, 1'b0, 1'b0, "t1_acc");
        a_valid = 1'b0;
        step(0, 1'b1, 8'hA1, 1'b0, 1'b0, "t1_b0");
        step(0, 1'b1, 8'hB2, 1'b0, 1'b0, "t1_b1");
        step(0, 1'b1, 8'hC3, 1'b0, 1'b0, "t1_b2");
        step(0, 1'b1, 8'hD4, 1'b1, 1'b1, "t1_b3");
        step(0, 1'b0, 8'h00, 1'b0, 1'b1, "t1_idle");

        // Two bytes only
        a_valid = 1'b1; a_nb = 3'd2;
        step(0, 1'b0, 8'h00, 1'b0, 1'b0, "t3_acc");
        a_valid = 1'b0;
        step(0, 1'b1, 8'hA1, 1'b0, 1'b0, "t3_b0");
        step(0, 1'b1, 8'hB2, 1'b1, 1'b1, "t3_b1");
        step(0, 1'b0, 8'h00, 1'b0, 1'b1, "t3_idle");

        // A count above N_BYTES sends the whole word
        a_valid = 1'b1; a_pal = 32'h0F1E2D3C; a_nb = 3'd6;
        step(0, 1'b0, 8'h00, 1'b0, 1'b0, "t3b_acc");
        a_valid = 1'b0;
        step(0, 1'b1, 8'h0F, 1'b0, 1'b0, "t3b_b0");
        step(0, 1'b1, 8'h1E, 1'b0, 1'b0, "t3b_b1");
        step(0, 1'b1, 8'h2D, 1'b0, 1'b0, "t3b_b2");
        step(0, 1'b1, 8'h3C, 1'b1, 1'b1, "t3b_b3");

        // Stall of three cycles after the 2nd byte. During the stall the
        // inputs change and i_valid is raised; the word in flight is unaffected.
        // The held request is then accepted right after o_done.
        a_valid = 1'b1; a_pal = 32'hA1B2C3D4; a_nb = 3'd0;
        step(0, 1'b0, 8'h00, 1'b0, 1'b0, "t4_acc");
        a_valid = 1'b0;
        step(0, 1'b1, 8'hA1, 1'b0, 1'b0, "t4_b0");
        step(0, 1'b1, 8'hB2, 1'b0, 1'b0, "t4_b1");
        a_full = 1'b1; a_valid = 1'b1; a_pal = 32'h55667788; a_nb = 3'd1;
        for (int i = 0; i < 3; i++) begin
            step(0, 1'b0, 8'h00, 1'b0, 1'b0, "t4_stall");
            check_val("t4_hold", 64'(a_byte), 64'hB2);
        end
        a_full = 1'b0;
        step(0, 1'b1, 8'hC3, 1'b0, 1'b0, "t4_b2");
        step(0, 1'b1, 8'hD4, 1'b1, 1'b1, "t4_b3");
        step(0, 1'b0, 8'h00, 1'b0, 1'b0, "t4_acc2");
        a_valid = 1'b0;
        step(0, 1'b1, 8'h55, 1'b1, 1'b1, "t4_n0");

        // Reset mid-word; it takes priority over i_valid in the same cycle
        a_valid = 1'b1; a_pal = 32'hA1B2C3D4; a_nb = 3'd0;
        step(0, 1'b0, 8'h00, 1'b0, 1'b0, "t5_acc");
        a_valid = 1'b0;
        step(0, 1'b1, 8'hA1, 1'b0, 1'b0, "t5_b0");
        step(0, 1'b1, 8'hB2, 1'b0, 1'b0, "t5_b1");
        a_rst = 1'b1; a_valid = 1'b1;
        step(0, 1'b0, 8'h00, 1'b0, 1'b1, "t5_rst");
        check_val("t5_rst_byte", 64'(a_byte), 64'h00);
        a_rst = 1'b0; a_valid = 1'b0;
        step(0, 1'b0, 8'h00, 1'b0, 1'b1, "t5_quiet");
        a_valid = 1'b1;
        step(0, 1'b0, 8'h00, 1'b0, 1'b0, "t5_acc2");
        a_valid = 1'b0;
        step(0, 1'b1, 8'hA1, 1'b0, 1'b0, "t5_r0");
        step(0, 1'b1, 8'hB2, 1'b0, 1'b0, "t5_r1");
        step(0, 1'b1, 8'hC3, 1'b0, 1'b0, "t5_r2");
        step(0, 1'b1, 8'hD4, 1'b1, 1'b1, "t5_r3");

        // LSB first: full word, then three bytes
        b_valid = 1'b1; b_pal = 32'hA1B2C3D4; b_nb = 3'd0;
        step(1, 1'b0, 8'h00, 1'b0, 1'b0, "t2_acc");
        b_valid = 1'b0;
        step(1, 1'b1, 8'hD4, 1'b0, 1'b0, "t2_b0");
        step(1, 1'b1, 8'hC3, 1'b0, 1'b0, "t2_b1");
        step(1, 1'b1, 8'hB2, 1'b0, 1'b0, "t2_b2");
        step(1, 1'b1, 8'hA1, 1'b1, 1'b1, "t2_b3");
        b_valid = 1'b1; b_nb = 3'd3;
        step(1, 1'b0, 8'h00, 1'b0, 1'b0, "t2c_acc");
        b_valid = 1'b0;
        step(1, 1'b1, 8'hD4, 1'b0, 1'b0, "t2c_b0");
        step(1, 1'b1, 8'hC3, 1'b0, 1'b0, "t2c_b1");
        step(1, 1'b1, 8'hB2, 1'b1, 1'b1, "t2c_b2");
        step(1, 1'b0, 8'h00, 1'b0, 1'b1, "t2c_idle");

        // 64-bit: two words with i_valid held between them
        c_valid = 1'b1; c_pal = 64'h0102030405060708; c_nb = 4'd0;
        step(2, 1'b0, 8'h00, 1'b0, 1'b0, "t6_acc1");
        for (int i = 0; i < 8; i++) begin
            step(2, 1'b1, 8'(i + 1), (i == 7), (i == 7), "t6_w1");
        end
        c_pal = 64'h1112131415161718;
        step(2, 1'b0, 8'h00, 1'b0, 1'b0, "t6_acc2");
        c_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(2, 1'b1, 8'(8'h11 + i), (i == 7), (i == 7), "t6_w2");
        end
        step(2, 1'b0, 8'h00, 1'b0, 1'b1, "t6_idle");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
